// File: rtl/inject_mux.sv
// inject_mux: merges N_CH credit-based flit sources onto one injection port, granting whole packets atomically.
// Build option: define INJECT_MUX_PRIO_EN to give channel 0 strict priority at every packet boundary.
module inject_mux #(
  parameter int N_CH       = 2,
  parameter int FLIT_SIZE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_CH-1:0]           src_rx_i,
  output logic [N_CH-1:0]           src_credit_o,
  input  logic [N_CH*FLIT_SIZE-1:0] src_data_i,
  output logic                      tx_o,
  input  logic                      credit_i,
  output logic [FLIT_SIZE-1:0]      data_o,
  output logic [N_CH-1:0]           grant_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(N_CH);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SIZE, S_PAYLOAD} state_t;

  state_t                         r_state;
  logic [IW-1:0]                  r_owner;
  logic [IW-1:0]                  r_last;
  logic [N_CH-1:0]                r_grant;
  logic [FLIT_SIZE-1:0]           r_remain;

  logic [N_CH-1:0]                w_empty;
  logic [N_CH-1:0]                w_full;
  logic [N_CH-1:0]                w_push;
  logic [N_CH-1:0]                w_pop;
  logic [N_CH-1:0][FLIT_SIZE-1:0] w_head;
  logic [FLIT_SIZE-1:0]           w_owner_head;
  logic                           w_owner_vld;
  logic                           w_xfer;
  logic [IW-1:0]                  w_win;
  logic                           w_found;
  int                             w_idx;

  // Per-channel FIFO: storage is not reset, only the pointers and occupancy.
  for (genvar c = 0; c < N_CH; c++) begin : g_fifo
    logic [FLIT_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_cnt;

    assign w_full[c]  = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty[c] = (r_cnt == '0);
    assign w_push[c]  = src_rx_i[c] & ~w_full[c];
    assign w_pop[c]   = w_xfer & (r_owner == IW'(c));
    assign w_head[c]  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
      if (w_push[c]) begin
        r_mem[r_wptr] <= src_data_i[c*FLIT_SIZE +: FLIT_SIZE];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[c]) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop[c]) begin
          r_rptr <= r_rptr + AW'(1);
        end
        if (w_push[c] && !w_pop[c]) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (!w_push[c] && w_pop[c]) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign w_owner_head = w_head[r_owner];
  assign w_owner_vld  = (r_state != S_IDLE) && !w_empty[r_owner];
  assign w_xfer       = w_owner_vld && credit_i;

  assign src_credit_o = ~w_full;
  assign tx_o         = w_owner_vld;
  assign data_o       = (r_state != S_IDLE) ? w_owner_head : '0;
  assign grant_o      = r_grant;

  // Winner search starts one past the last winner and wraps.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
`ifdef INJECT_MUX_PRIO_EN
    if (!w_empty[0]) begin
      w_found = 1'b1;
    end
    for (int i = 1; i < N_CH; i++) begin
      w_idx = ((int'(r_last) - 1 + i) % (N_CH - 1)) + 1;
      if (!w_found && !w_empty[w_idx]) begin
        w_win   = IW'(w_idx);
        w_found = 1'b1;
      end
    end
`else
    for (int i = 1; i <= N_CH; i++) begin
      w_idx = (int'(r_last) + i) % N_CH;
      if (!w_found && !w_empty[w_idx]) begin
        w_win   = IW'(w_idx);
        w_found = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_last   <= IW'(N_CH - 1);
      r_grant  <= '0;
      r_remain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_HEAD;
            r_owner <= w_win;
            r_grant <= N_CH'(1) << w_win;
`ifdef INJECT_MUX_PRIO_EN
            if (w_win != '0) begin
              r_last <= w_win;
            end
`else
            r_last  <= w_win;
`endif
          end
        end
        S_HEAD: begin
          if (w_xfer) begin
            r_state <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (w_xfer) begin
            r_remain <= w_owner_head;
            if (w_owner_head == '0) begin
              r_state <= S_IDLE;
              r_grant <= '0;
            end else begin
              r_state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_remain <= r_remain - FLIT_SIZE'(1);
            if (r_remain == FLIT_SIZE'(1)) begin
              r_state <= S_IDLE;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inject_mux.sv
// Directed self-checking bench for inject_mux: two sources, one downstream sink with controllable credit.
module tb_inject_mux;
  localparam int N_CH  = 2;
  localparam int FW    = 32;
  localparam int DEPTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic [N_CH-1:0]      src_rx;
  logic [N_CH-1:0]      src_credit;
  logic [N_CH*FW-1:0]   src_data;
  logic                 tx;
  logic                 credit;
  logic [FW-1:0]        data;
  logic [N_CH-1:0]      grant;

  inject_mux #(.N_CH(N_CH), .FLIT_SIZE(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_rx_i    (src_rx),
    .src_credit_o(src_credit),
    .src_data_i  (src_data),
    .tx_o        (tx),
    .credit_i    (credit),
    .data_o      (data),
    .grant_o     (grant)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc1  = 0;

  logic [FW-1:0]   q0[$];
  logic [FW-1:0]   q1[$];
  int              acc0_cyc[$];
  logic [FW-1:0]   out_d[$];
  logic [N_CH-1:0] out_g[$];
  int              out_c[$];
  logic [FW-1:0]   exp_d[$];
  logic [N_CH-1:0] exp_g[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source driver: present queue heads just after each rising edge.
  initial begin
    src_rx   = '0;
    src_data = '0;
    forever begin
      @(posedge clk);
      #1;
      src_rx[0]       = rst_n && (q0.size() != 0);
      src_data[0+:FW] = (q0.size() != 0) ? q0[0] : '0;
      src_rx[1]       = rst_n && (q1.size() != 0);
      src_data[FW+:FW] = (q1.size() != 0) ? q1[0] : '0;
    end
  end

  // Handshake observer on the falling edge: logs accepted inputs and transferred outputs.
  initial forever begin
    @(negedge clk);
    if (rst_n && src_rx[0] && src_credit[0]) begin
      acc0_cyc.push_back(cyc);
      void'(q0.pop_front());
    end
    if (rst_n && src_rx[1] && src_credit[1]) begin
      acc1++;
      void'(q1.pop_front());
    end
    if (rst_n && tx && credit) begin
      out_d.push_back(data);
      out_g.push_back(grant);
      out_c.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    credit = 1'b1;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_d.delete();
    out_g.delete();
    out_c.delete();
    acc0_cyc.delete();
    acc1 = 0;
    exp_d.delete();
    exp_g.delete();
  endtask

  task automatic wait_out(input string tag, input int n);
    int k;
    k = 0;
    while (out_d.size() < n && k < 300) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk_eq({tag, "_cnt"}, out_d.size(), n);
  endtask

  task automatic exp_push(input logic [FW-1:0] d, input logic [N_CH-1:0] g);
    exp_d.push_back(d);
    exp_g.push_back(g);
  endtask

  task automatic exp_pkt4(input logic [N_CH-1:0] g, input logic [FW-1:0] h,
                          input logic [FW-1:0] p1, input logic [FW-1:0] p2);
    exp_push(h, g);
    exp_push(32'd2, g);
    exp_push(p1, g);
    exp_push(p2, g);
  endtask

  task automatic cmp_out(input string tag);
    wait_out(tag, exp_d.size());
    repeat (4) @(posedge clk);
    #2;
    chk_eq({tag, "_total"}, out_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      chk_eq($sformatf("%s_d%0d", tag, i), out_d[i], exp_d[i]);
      chk_eq($sformatf("%s_g%0d", tag, i), out_g[i], exp_g[i]);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    credit = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_eq("rst_tx", tx, 0);
    chk_eq("rst_data", data, 0);
    chk_eq("rst_grant", grant, 0);
    chk_eq("rst_credit", src_credit, 2'b11);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk_eq("idle_tx", tx, 0);
    chk_eq("idle_grant", grant, 0);

    // Single packet on channel 0
    q0 = '{32'h0102, 32'd3, 32'hA, 32'hB, 32'hC};
    exp_push(32'h0102, 2'b01);
    exp_push(32'd3, 2'b01);
    exp_push(32'hA, 2'b01);
    exp_push(32'hB, 2'b01);
    exp_push(32'hC, 2'b01);
    cmp_out("t1");
    chk_eq("t1_latency", out_c[0] - acc0_cyc[0], 2);
    for (int i = 1; i < 5; i++) begin
      chk_eq($sformatf("t1_gap%0d", i), out_c[i] - out_c[i-1], 1);
    end
    chk_eq("t1_end_tx", tx, 0);
    chk_eq("t1_end_grant", grant, 0);

    // Two channels, two packets each, offered together
    do_reset();
    q0 = '{32'hA0, 32'd2, 32'hA1, 32'hA2, 32'hB0, 32'd2, 32'hB1, 32'hB2};
    q1 = '{32'hC0, 32'd2, 32'hC1, 32'hC2, 32'hD0, 32'd2, 32'hD1, 32'hD2};
`ifdef INJECT_MUX_PRIO_EN
    exp_pkt4(2'b01, 32'hA0, 32'hA1, 32'hA2);
    exp_pkt4(2'b01, 32'hB0, 32'hB1, 32'hB2);
    exp_pkt4(2'b10, 32'hC0, 32'hC1, 32'hC2);
    exp_pkt4(2'b10, 32'hD0, 32'hD1, 32'hD2);
`else
    exp_pkt4(2'b01, 32'hA0, 32'hA1, 32'hA2);
    exp_pkt4(2'b10, 32'hC0, 32'hC1, 32'hC2);
    exp_pkt4(2'b01, 32'hB0, 32'hB1, 32'hB2);
    exp_pkt4(2'b10, 32'hD0, 32'hD1, 32'hD2);
`endif
    cmp_out("t2");
    for (int i = 1; i < 16; i++) begin
      chk_eq($sformatf("t2_gap%0d", i), out_c[i] - out_c[i-1], (i % 4 == 0) ? 2 : 1);
    end

    // Backpressure on channel 1
    do_reset();
    credit = 1'b0;
    q1 = '{32'h77, 32'd6, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    repeat (5) @(posedge clk);
    #2;
    chk_eq("t3_hold_mid", data, 32'h77);
    repeat (5) @(posedge clk);
    #2;
    chk_eq("t3_accepted", acc1, DEPTH);
    chk_eq("t3_credit1", src_credit[1], 0);
    chk_eq("t3_hold_tx", tx, 1);
    chk_eq("t3_hold_data", data, 32'h77);
    chk_eq("t3_hold_grant", grant, 2'b10);
    chk_eq("t3_no_out", out_d.size(), 0);
    credit = 1'b1;
    exp_push(32'h77, 2'b10);
    exp_push(32'd6, 2'b10);
    for (int i = 1; i <= 6; i++) begin
      exp_push(FW'(i), 2'b10);
    end
    cmp_out("t3");

    // Zero-size packet
    do_reset();
    q1 = '{32'h55, 32'd0};
    exp_push(32'h55, 2'b10);
    exp_push(32'd0, 2'b10);
    cmp_out("t4");
    chk_eq("t4_grant", grant, 0);
    chk_eq("t4_tx", tx, 0);

    // Starved owner while channel 1 waits
    do_reset();
    q0 = '{32'h0A00, 32'd5};
    q1 = '{32'h1100, 32'd1, 32'h11};
    exp_push(32'h0A00, 2'b01);
    exp_push(32'd5, 2'b01);
    for (int i = 1; i <= 5; i++) begin
      exp_push(32'h0A00 + FW'(i), 2'b01);
    end
    exp_push(32'h1100, 2'b10);
    exp_push(32'd1, 2'b10);
    exp_push(32'h11, 2'b10);
    wait_out("t5_pre", 2);
    repeat (3) @(posedge clk);
    #2;
    chk_eq("t5_gap_tx", tx, 0);
    chk_eq("t5_gap_grant", grant, 2'b01);
    chk_eq("t5_gap_cnt", out_d.size(), 2);
    repeat (3) @(posedge clk);
    #2;
    for (int i = 1; i <= 5; i++) begin
      q0.push_back(32'h0A00 + FW'(i));
    end
    cmp_out("t5");

    // Reset asserted mid-packet
    do_reset();
    q0 = '{32'hE0, 32'd5, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    wait_out("t6_pre", 3);
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk_eq("t6_rst_tx", tx, 0);
    chk_eq("t6_rst_data", data, 0);
    chk_eq("t6_rst_grant", grant, 0);
    chk_eq("t6_rst_credit", src_credit, 2'b11);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_d.delete();
    out_g.delete();
    out_c.delete();
    q1 = '{32'h99, 32'd1, 32'h98};
    exp_push(32'h99, 2'b10);
    exp_push(32'd1, 2'b10);
    exp_push(32'h98, 2'b10);
    cmp_out("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
